// File: rtl/apb4_archinfo_fetch.sv
// APB4 read-only master that fetches the SYS/IDL/IDH architecture-information words
// after reset and on each start request, and holds them with decoded fields and status.
module apb4_archinfo_fetch #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned TIMEOUT    = 255,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        start_i,
  output logic [31:0] paddr,
  output logic [2:0]  pprot,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  input  logic        pready,
  input  logic [31:0] prdata,
  input  logic        pslverr,
  output logic        busy_o,
  output logic        valid_o,
  output logic        err_o,
  output logic [1:0]  err_idx_o,
  output logic [31:0] sys_o,
  output logic [31:0] idl_o,
  output logic [31:0] idh_o,
  output logic [11:0] clk_freq_o,
  output logic [7:0]  sram_size_o
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StSetup  = 3'd1;
  localparam logic [2:0] StAccess = 3'd2;
  localparam logic [2:0] StDone   = 3'd3;
  localparam logic [2:0] StErr    = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            first_q;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [1:0]      err_idx_q, err_idx_d;
  logic [31:0]     sys_q, sys_d, idl_q, idl_d, idh_q, idh_d;
  logic [31:0]     paddr_q, paddr_d;
  logic            start_req;
  logic            timeout_hit;

  // first_q marks the first cycle out of reset for the automatic fetch
  assign start_req   = start_i || (AUTO_START && first_q);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntLast);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    sys_d     = sys_q;
    idl_d     = idl_q;
    idh_d     = idh_q;
    case (state_q)
      StIdle, StDone, StErr: begin
        if (start_req) begin
          state_d   = StSetup;
          idx_d     = 2'd0;
          valid_d   = 1'b0;
          err_d     = 1'b0;
          err_idx_d = 2'd0;
        end
      end
      StSetup: begin
        state_d = StAccess;
        cnt_d   = '0;
      end
      StAccess: begin
        if (pready) begin
          if (pslverr) begin
            state_d   = StErr;
            err_d     = 1'b1;
            err_idx_d = idx_q;
          end else begin
            case (idx_q)
              2'd0:    sys_d = prdata;
              2'd1:    idl_d = prdata;
              default: idh_d = prdata;
            endcase
            if (idx_q == 2'd2) begin
              state_d = StDone;
              valid_d = 1'b1;
            end else begin
              state_d = StSetup;
              idx_d   = idx_q + 2'd1;
            end
          end
        end else if (timeout_hit) begin
          state_d   = StErr;
          err_d     = 1'b1;
          err_idx_d = idx_q;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    paddr_d = BASE_ADDR + {28'h0, idx_d, 2'b00};
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q   <= StIdle;
      idx_q     <= 2'd0;
      cnt_q     <= '0;
      first_q   <= 1'b1;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= 2'd0;
      sys_q     <= 32'h0;
      idl_q     <= 32'h0;
      idh_q     <= 32'h0;
      paddr_q   <= BASE_ADDR;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      first_q   <= 1'b0;
      valid_q   <= valid_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
      sys_q     <= sys_d;
      idl_q     <= idl_d;
      idh_q     <= idh_d;
      paddr_q   <= paddr_d;
    end
  end

  assign psel        = (state_q == StSetup) || (state_q == StAccess);
  assign penable     = (state_q == StAccess);
  assign busy_o      = psel;
  assign paddr       = paddr_q;
  assign pprot       = 3'b000;
  assign pwrite      = 1'b0;
  assign pwdata      = 32'h0;
  assign pstrb       = 4'h0;
  assign valid_o     = valid_q;
  assign err_o       = err_q;
  assign err_idx_o   = err_idx_q;
  assign sys_o       = sys_q;
  assign idl_o       = idl_q;
  assign idh_o       = idh_q;
  assign clk_freq_o  = sys_q[19:8];
  assign sram_size_o = sys_q[7:0];

endmodule

// File: tb/tb_apb4_archinfo_fetch.sv
// Scoreboard bench for apb4_archinfo_fetch: a slave model answers from a per-fetch plan, the
// stimulus pushes expected outcomes/addresses, and a monitor compares on each completion.
`timescale 1ns/1ps
module tb_apb4_archinfo_fetch;

  localparam int To = 4;
  localparam logic [31:0] Base = 32'h0000_0000;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready = 1'b0;
  logic [31:0] prdata = 32'h0;
  logic        pslverr = 1'b0;
  logic        busy_o, valid_o, err_o;
  logic [1:0]  err_idx_o;
  logic [31:0] sys_o, idl_o, idh_o;
  logic [11:0] clk_freq_o;
  logic [7:0]  sram_size_o;

  apb4_archinfo_fetch #(
    .BASE_ADDR (Base),
    .TIMEOUT   (To),
    .AUTO_START(1'b1)
  ) dut (
    .hclk       (hclk),
    .hresetn    (hresetn),
    .start_i    (start_i),
    .paddr      (paddr),
    .pprot      (pprot),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .pwdata     (pwdata),
    .pstrb      (pstrb),
    .pready     (pready),
    .prdata     (prdata),
    .pslverr    (pslverr),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
    .err_o      (err_o),
    .err_idx_o  (err_idx_o),
    .sys_o      (sys_o),
    .idl_o      (idl_o),
    .idh_o      (idh_o),
    .clk_freq_o (clk_freq_o),
    .sram_size_o(sram_size_o)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic        valid;
    logic        err;
    logic [1:0]  eidx;
    logic [31:0] sys;
    logic [31:0] idl;
    logic [31:0] idh;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          done_cnt = 0;

  // Plan for the current fetch: wait states, data and slave error per word
  int          pw[3];
  logic [31:0] pd[3];
  logic        pe[3];
  logic [31:0] mw[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference: walk the words in order; a word is lost to timeout if its wait exceeds To-1
  task automatic plan_fetch();
    exp_t e;
    e.err  = 1'b0;
    e.eidx = 2'd0;
    e.cyc  = 0;
    for (int k = 0; k < 3; k++) begin
      addr_q.push_back(Base + 32'(4 * k));
      if (pw[k] >= To) begin
        e.cyc += 1 + To;
        e.err  = 1'b1;
        e.eidx = 2'(k);
        break;
      end
      e.cyc += 2 + pw[k];
      if (pe[k]) begin
        e.err  = 1'b1;
        e.eidx = 2'(k);
        break;
      end
      mw[k] = pd[k];
    end
    e.valid = !e.err;
    e.sys   = mw[0];
    e.idl   = mw[1];
    e.idh   = mw[2];
    exp_q.push_back(e);
  endtask

  // Slave: responds on the (wait+1)-th ACCESS cycle; drives junk while not ready
  int sn = 0;
  int sk;
  always @(negedge hclk) begin
    if (psel && penable) begin
      sk = int'(paddr[3:2]);
      if (sk < 3 && sn == pw[sk]) begin
        pready  = 1'b1;
        prdata  = pd[sk];
        pslverr = pe[sk];
      end else begin
        pready  = 1'b0;
        prdata  = $urandom;
        pslverr = 1'($urandom_range(0, 1));
      end
      sn++;
    end else begin
      sn      = 0;
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = $urandom;
    end
  end

  // Monitor
  int          bcyc = 0;
  logic        pbusy = 1'b0;
  logic [31:0] cur_addr = 32'h0;
  exp_t        me;
  always @(negedge hclk) begin
    if (!hresetn) begin
      bcyc  = 0;
      pbusy = 1'b0;
    end else begin
      if (psel && !penable) begin
        if (addr_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_transfer: got paddr %h, expected no transfer", paddr);
        end else begin
          chk("paddr", paddr, addr_q.pop_front());
        end
        cur_addr = paddr;
      end
      if (psel && penable) chk("paddr_stable", paddr, cur_addr);
      if (psel) chk("write_side_zero", {pwrite, pstrb, pprot, pwdata[23:0]}, 32'h0);
      if (busy_o) begin
        bcyc++;
        chk("status_while_busy", {30'h0, valid_o, err_o}, 32'h0);
      end
      if (pbusy && !busy_o) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_completion: got valid %b err %b, expected none", valid_o,
                   err_o);
        end else begin
          me = exp_q.pop_front();
          chk("valid_o", 32'(valid_o), 32'(me.valid));
          chk("err_o", 32'(err_o), 32'(me.err));
          chk("err_idx_o", 32'(err_idx_o), 32'(me.eidx));
          chk("sys_o", sys_o, me.sys);
          chk("idl_o", idl_o, me.idl);
          chk("idh_o", idh_o, me.idh);
          chk("clk_freq_o", 32'(clk_freq_o), 32'(me.sys[19:8]));
          chk("sram_size_o", 32'(sram_size_o), 32'(me.sys[7:0]));
          chk("busy_cycles", 32'(bcyc), 32'(me.cyc));
          chk("psel_after", 32'(psel), 32'h0);
        end
        done_cnt++;
        bcyc = 0;
      end
      pbusy = busy_o;
    end
  end

  task automatic wait_for(input int tgt, input string name);
    int t = 0;
    while (done_cnt < tgt && t < 300) begin
      @(negedge hclk);
      t++;
    end
    if (done_cnt < tgt) begin
      n_chk++;
      $display("FAIL %s: fetch did not complete, got %0d completions, expected %0d", name,
               done_cnt, tgt);
    end
  endtask

  task automatic pulse_start();
    @(negedge hclk);
    start_i = 1'b1;
    @(negedge hclk);
    start_i = 1'b0;
  endtask

  task automatic do_fetch(input string name);
    int tgt;
    plan_fetch();
    tgt = done_cnt + 1;
    pulse_start();
    wait_for(tgt, name);
  endtask

  task automatic wait_access(input int word, input string name);
    int t = 0;
    while (!(psel && penable && paddr == Base + 32'(4 * word)) && t < 100) begin
      @(negedge hclk);
      t++;
    end
    if (t >= 100) begin
      n_chk++;
      $display("FAIL %s: ACCESS of word %0d not seen, got paddr %h", name, word, paddr);
    end
  endtask

  task automatic rnd_data();
    for (int k = 0; k < 3; k++) pd[k] = $urandom;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int tgt;
    pd = '{32'h0001_3220, 32'hA5A5_0001, 32'h0020_2312};
    pw = '{0, 0, 0};
    pe = '{1'b0, 1'b0, 1'b0};
    mw = '{32'h0, 32'h0, 32'h0};
    repeat (3) @(negedge hclk);
    chk("rst_psel", 32'(psel), 32'h0);
    chk("rst_penable", 32'(penable), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_err", {30'h0, err_o, 1'b0} | 32'(err_idx_o), 32'h0);
    chk("rst_paddr", paddr, Base);
    chk("rst_words", sys_o | idl_o | idh_o, 32'h0);

    // Automatic fetch after reset release
    plan_fetch();
    tgt = done_cnt + 1;
    hresetn = 1'b1;
    wait_for(tgt, "auto_fetch");
    chk("dir_clk_freq", 32'(clk_freq_o), 32'h132);
    chk("dir_sram_size", 32'(sram_size_o), 32'h20);

    rnd_data();
    pw = '{0, 2, 0};
    do_fetch("wait_states");

    rnd_data();
    pw = '{0, 0, 1};
    pe = '{1'b0, 1'b0, 1'b1};
    do_fetch("slverr_word2");
    pe = '{1'b0, 1'b0, 1'b0};

    rnd_data();
    pw = '{7, 0, 0};
    do_fetch("timeout_word0");

    // start_i during ACCESS of word 1 must not restart or queue
    rnd_data();
    pw = '{0, 0, 0};
    plan_fetch();
    tgt = done_cnt + 1;
    pulse_start();
    wait_access(1, "start_ignored");
    start_i = 1'b1;
    @(negedge hclk);
    start_i = 1'b0;
    wait_for(tgt, "start_ignored");
    repeat (4) @(negedge hclk);
    chk("no_restart", 32'(busy_o), 32'h0);
    rnd_data();
    do_fetch("refetch_in_done");

    // Reset during ACCESS of word 1
    rnd_data();
    pw = '{0, 3, 0};
    plan_fetch();
    pulse_start();
    wait_access(1, "reset_mid");
    hresetn = 1'b0;
    @(negedge hclk);
    chk("midrst_psel", {30'h0, psel, penable}, 32'h0);
    chk("midrst_valid", 32'(valid_o), 32'h0);
    chk("midrst_words", sys_o | idl_o | idh_o, 32'h0);
    exp_q.delete();
    addr_q.delete();
    mw = '{32'h0, 32'h0, 32'h0};
    rnd_data();
    pw = '{0, 0, 0};
    plan_fetch();
    tgt = done_cnt + 1;
    @(negedge hclk);
    hresetn = 1'b1;
    wait_for(tgt, "post_reset_fetch");

    for (int i = 0; i < 12; i++) begin
      rnd_data();
      for (int k = 0; k < 3; k++) begin
        pw[k] = ($urandom_range(0, 5) == 0) ? 6 : int'($urandom_range(0, 3));
        pe[k] = ($urandom_range(0, 7) == 0);
      end
      do_fetch("random_fetch");
    end

    repeat (3) @(negedge hclk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
